// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef dataWidth
`define dataWidth 32
`endif

package mem_ctrl_pkg;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_DATA = 1'b0,
        PORT_IF   = 1'b1
    } port_t;

    function automatic logic [2:0] len_to_n(input logic [1:0] l);
        return {1'b0, l} + 3'd1;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises data loads/stores and instruction fetches onto one byte-wide synchronous RAM.
// Latency: read n+1 edges, write n edges from acceptance; one idle cycle between transactions.
// Backpressure: one pending slot per port; mem_busy covers the data port, extra requests are dropped.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW   = 17,
    parameter int IF_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             rw_flag,
    input  logic [`addrWidth-1:0]  addr,
    input  logic [`dataWidth-1:0]  write_data,
    input  logic [1:0]             len,
    output logic [`dataWidth-1:0]  read_data,
    output logic                   mem_busy,
    output logic                   mem_done,
    input  logic                   if_req,
    input  logic [`addrWidth-1:0]  if_addr,
    output logic [`dataWidth-1:0]  if_data,
    output logic                   if_done,
    output logic [RAM_AW-1:0]      ram_a,
    output logic                   ram_wr,
    output logic [7:0]             ram_dout,
    input  logic [7:0]             ram_din
);

    localparam logic [RAM_AW-1:0] A_ONE = RAM_AW'(1);

    state_t state, state_nxt;
    port_t  port;

    logic                  d_vld, d_wr;
    logic [RAM_AW-1:0]     d_addr;
    logic [1:0]            d_len;
    logic [`dataWidth-1:0] d_wdata;
    logic                  f_vld;
    logic [RAM_AW-1:0]     f_addr;

    logic [2:0]            step, cur_n;
    logic [`dataWidth-1:0] cur_wdata, rd_buf, rd_merge;

    logic                  d_new, f_new, start_d, start_f, fin;
    logic                  d_sel_wr;
    logic [RAM_AW-1:0]     d_sel_addr, f_sel_addr;
    logic [1:0]            d_sel_len;
    logic [`dataWidth-1:0] d_sel_wdata;
    logic [1:0]            cap_idx, wr_idx;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[`addrWidth-1:RAM_AW], if_addr[`addrWidth-1:RAM_AW]};

    // A request on a port already queued or in service is dropped.
    assign d_new = (rw_flag == RW_READ || rw_flag == RW_WRITE) && !d_vld
                   && !(state != IDLE && port == PORT_DATA);
    assign f_new = if_req && !f_vld && !(state != IDLE && port == PORT_IF);

    assign d_sel_wr    = d_vld ? d_wr    : (rw_flag == RW_WRITE);
    assign d_sel_addr  = d_vld ? d_addr  : addr[RAM_AW-1:0];
    assign d_sel_len   = d_vld ? d_len   : len;
    assign d_sel_wdata = d_vld ? d_wdata : write_data;
    assign f_sel_addr  = f_vld ? f_addr  : if_addr[RAM_AW-1:0];

    assign cap_idx  = 2'(step - 3'd1);
    assign wr_idx   = 2'(step + 3'd1);
    assign mem_busy = d_vld || (state != IDLE && port == PORT_DATA);

    always_comb begin
        state_nxt = state;
        start_d   = 1'b0;
        start_f   = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (d_vld || d_new) begin
                    start_d   = 1'b1;
                    state_nxt = d_sel_wr ? WRITE : READ;
                end else if (f_vld || f_new) begin
                    start_f   = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (step == cur_n) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (step + 3'd1 == cur_n) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte captured at this edge was addressed two edges earlier.
    always_comb begin
        rd_merge = rd_buf;
        if (step != 3'd0)
            rd_merge[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            port      <= PORT_DATA;
            d_vld     <= 1'b0;
            d_wr      <= 1'b0;
            d_addr    <= '0;
            d_len     <= '0;
            d_wdata   <= '0;
            f_vld     <= 1'b0;
            f_addr    <= '0;
            step      <= '0;
            cur_n     <= '0;
            cur_wdata <= '0;
            rd_buf    <= '0;
            read_data <= '0;
            if_data   <= '0;
            mem_done  <= 1'b0;
            if_done   <= 1'b0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            state    <= state_nxt;
            mem_done <= 1'b0;
            if_done  <= 1'b0;

            if (d_new) begin
                d_vld   <= 1'b1;
                d_wr    <= (rw_flag == RW_WRITE);
                d_addr  <= addr[RAM_AW-1:0];
                d_len   <= len;
                d_wdata <= write_data;
            end
            if (f_new) begin
                f_vld  <= 1'b1;
                f_addr <= if_addr[RAM_AW-1:0];
            end
            if (start_d) d_vld <= 1'b0;
            if (start_f) f_vld <= 1'b0;

            if (start_d || start_f) begin
                port      <= start_d ? PORT_DATA : PORT_IF;
                ram_a     <= start_d ? d_sel_addr : f_sel_addr;
                step      <= '0;
                rd_buf    <= '0;
                cur_n     <= start_d ? len_to_n(d_sel_len) : 3'(IF_BYTES);
                cur_wdata <= d_sel_wdata;
                if (start_d && d_sel_wr) begin
                    ram_wr   <= 1'b1;
                    ram_dout <= d_sel_wdata[7:0];
                end
            end else if (state == READ) begin
                rd_buf <= rd_merge;
                step   <= step + 3'd1;
                if (step + 3'd1 < cur_n)
                    ram_a <= ram_a + A_ONE;
                if (fin) begin
                    if (port == PORT_DATA) begin
                        mem_done  <= 1'b1;
                        read_data <= rd_merge;
                    end else begin
                        if_done <= 1'b1;
                        if_data <= rd_merge;
                    end
                end
            end else if (state == WRITE) begin
                if (fin) begin
                    ram_wr   <= 1'b0;
                    mem_done <= 1'b1;
                end else begin
                    ram_a    <= ram_a + A_ONE;
                    ram_dout <= cur_wdata[{wr_idx, 3'b000} +: 8];
                    step     <= step + 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller directly downstream of ex_ls.
- Serialises 1/2/4-byte load/store requests from ex_ls, plus 32-bit instruction fetches from the fetch stage, onto a single byte-wide synchronous RAM port (little-endian).
- Returns assembled read data with a one-cycle done pulse per port.
- Data requests take priority over fetches.

Parameters:
- RAM_AW, 17, number of low address bits driven to the RAM.
- IF_BYTES, 4, bytes per instruction fetch.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- rw_flag  in  2  data request from ex_ls: 01 = read, 10 = write, 00/11 = none. One-cycle pulse.
- addr  in  `addrWidth  data byte address.
- write_data  in  `dataWidth  store data; low bytes are used.
- len  in  2  data size: byte count = len+1 (00 = 1, 01 = 2, 11 = 4).
- read_data  out  `dataWidth  assembled load data; zero-extended, ex_ls extends.
- mem_busy  out  1  high while a data request is pending or in service.
- mem_done  out  1  one-cycle pulse: data request complete.
- if_req  in  1  fetch request pulse.
- if_addr  in  `addrWidth  fetch address.
- if_data  out  `dataWidth  fetched instruction.
- if_done  out  1  one-cycle pulse: fetch complete.
- ram_a  out  RAM_AW  RAM byte address.
- ram_wr  out  1  RAM write enable.
- ram_dout  out  8  byte to RAM.
- ram_din  in  8  byte from RAM; valid the cycle after ram_a is registered by the RAM.

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, pending slots empty, byte index 0. ram_wr drops immediately; any in-flight transaction is abandoned and no done pulse is issued.
- Request capture:
  - A data request is latched into a one-entry pending slot (op, addr, len, wdata) at any edge where rw_flag is 01 or 10.
  - A fetch request is latched likewise when if_req = 1.
  - A request on a port whose slot is already occupied or in service is a protocol violation and is ignored.
- States: IDLE, READ, WRITE. Registers: port select (DATA/IF), 2-bit byte index k, byte count n.
- IDLE:
  - If the data slot is valid (including one captured this same edge), start it; otherwise, if the fetch slot is valid, start it (n = IF_BYTES, read).
  - Start means: ram_a <= addr[RAM_AW-1:0], k <= 0, and go to READ or WRITE.
  - For a write, also ram_wr <= 1 and ram_dout <= wdata[7:0].
- READ:
  - Byte k's address is driven during the cycle after edge E_k; ram_a increments each edge until byte n-1 has been issued.
  - Byte k is captured from ram_din at E_{k+2} into bits [8k+7:8k]; unused high bytes are 0.
  - At E_{n+1}, the last byte is written, the matching *_done is set to 1 and the state returns to IDLE.
  - Latency: acceptance edge E0 to done edge = n+1 (LB 2, LH 3, LW/fetch 5).
- WRITE:
  - Byte k is presented with ram_wr = 1 after E_k and committed by the RAM at E_{k+1}.
  - At E_n: mem_done <= 1, ram_wr <= 0, state returns to IDLE.
  - Latency n edges (SB 1, SW 4).
- Done pulses last exactly one cycle. read_data and if_data update only at completion and hold until the next completion on that port.
- Completion and restart: the edge that sets done also returns to IDLE. The next transaction starts at the following edge, giving one idle cycle between transactions.
- Simultaneous data and fetch pending in IDLE: data is serviced first and the fetch waits.
- Address arithmetic wraps modulo 2^RAM_AW.
- mem_busy = data slot valid OR (state != IDLE AND port == DATA). It is 0 in the cycle after mem_done.
- A fetch request arriving during data service waits in its slot; the reverse also holds.

Decomposition:
- The shared defines file holds:
  - rw_flag encodings (RW_NONE, RW_READ, RW_WRITE);
  - len encodings (LEN_B, LEN_H, LEN_W);
  - controller state encodings.
- `addrWidth and `dataWidth are already shared.
- No sub-module is needed: the two pending slots and the FSM fit in one module (~200 lines).

Test Plan:
- LW: RAM[0x100..0x103] = 78,56,34,12; rw_flag = 01, addr = 0x100, len = 11 at E0 -> ram_a = 100..103 on successive cycles; mem_done pulses at E5 with read_data = 0x12345678.
- SH then LBU: SH addr = 0x20, write_data = 0xBEEF -> ram_wr high 2 cycles, RAM[0x20] = EF, RAM[0x21] = BE, mem_done at E2. Then LBU addr = 0x21 -> read_data = 0x000000BE, done 2 edges after acceptance.
- Simultaneous requests: if_req with if_addr = 0x0 and SB addr = 0x40, data = 0xAA, both at E0 -> RAM[0x40] = AA with mem_done at E1. Fetch starts at E2 and if_done pulses at E7; mem_done and if_done are never high together.
- Data during fetch: fetch accepted at E0, LB at E2 -> mem_busy = 1 from E2; if_done at E5; LB starts at E6 and mem_done pulses at E8.
- Reset mid-write: SW accepted, rst low after the second byte -> ram_wr = 0 immediately; mem_done never pulses; after release, all outputs are 0 and a new LB completes normally.
- Wrap: LW at addr = 2^RAM_AW - 2 -> ram_a sequence is max-1, max, 0, 1.
